// File: rtl/r200_pkg.sv
// r200_pkg: shared fetch-unit state encoding and constants
package r200_pkg;
  typedef enum logic [1:0] {S_REQ, S_HOLD, S_KILL, S_FAULT} fetch_state_t;
  localparam logic [31:0] INSTR_BYTES = 32'd4;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/pc_fetch_adder32.sv
// adder32: 32-bit adder with carry-in; the carry-out is dropped so sums wrap modulo 2^32
module adder32
  import r200_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum
);
  assign sum = a + b + {31'd0, cin};
endmodule

// File: rtl/pc_fetch.sv
// pc_fetch: single-outstanding instruction fetch with branch redirect and misalign fault
module pc_fetch
  import r200_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        misalign
);
  fetch_state_t state, state_n;
  logic run, flt, flt_n, cap, bad, mis_n;
  logic [31:0] pc, pc_n, pc_inc, req_addr;
  adder32 u_inc (.a(pc), .b(INSTR_BYTES), .cin(1'b0), .sum(pc_inc));
  assign bad = br_target[1:0] != 2'b00;
  assign imem_req = run && (state == S_REQ || state == S_KILL);
  assign imem_addr = state == S_KILL ? req_addr : pc;
  assign if_valid = state == S_HOLD;
  assign mis_n = run && br_taken && bad && state != S_FAULT && !flt;
  // next state, next pc, data capture and pending-fault tracking
  always_comb begin
    state_n = state;
    pc_n = pc;
    flt_n = flt;
    cap = 1'b0;
    if (run) begin
      case (state)
        S_REQ:
          if (br_taken) begin
            pc_n = bad ? pc : br_target;
            flt_n = bad && !imem_ack;
            state_n = imem_ack ? (bad ? S_FAULT : S_REQ) : S_KILL;
          end else if (imem_ack) begin
            cap = 1'b1;
            pc_n = pc_inc;
            state_n = S_HOLD;
          end
        S_HOLD:
          if (br_taken) begin
            pc_n = bad ? pc : br_target;
            state_n = bad ? S_FAULT : S_REQ;
          end else if (if_ready) state_n = S_REQ;
        S_KILL: begin
          if (br_taken && !flt) begin
            pc_n = bad ? pc : br_target;
            flt_n = bad;
          end
          if (imem_ack) state_n = flt_n ? S_FAULT : S_REQ;
        end
        default: state_n = S_FAULT;
      endcase
    end
  end
  // state, pc, held request address and decode-side registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_REQ;
      run <= 1'b0;
      flt <= 1'b0;
      pc <= RESET_PC;
      req_addr <= RESET_PC;
      if_instr <= '0;
      if_pc <= '0;
      misalign <= 1'b0;
    end else begin
      state <= state_n;
      run <= 1'b1;
      flt <= flt_n;
      pc <= pc_n;
      if (state == S_REQ) req_addr <= pc;
      if (cap) begin
        if_instr <= imem_rdata;
        if_pc <= pc;
      end
      misalign <= mis_n;
    end
  end
endmodule
